writeback_select: RTL
=====================

WRITEBACK_SELECT -- requirements
Module: writeback_select

Interface
REQ-001 Parameter DATA_W, default 32, writeback data width; SHALL be >= 32.
REQ-002 Parameter REG_AW, default 4, destination register index width.
REQ-003 Parameter RAM_LAT, default 2, cycles from ld_issue to ram_result valid; legal range 1..4.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 alu_valid  in  1  ALU result present this cycle.
REQ-007 alu_result  in  DATA_W  ALU result.
REQ-008 alu_rd  in  REG_AW  ALU destination register.
REQ-009 ld_issue  in  1  load issued to RAM this cycle.
REQ-010 ld_rd  in  REG_AW  load destination register.
REQ-011 ld_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-012 ld_signed  in  1  1 sign-extend, 0 zero-extend (byte/halfword only).
REQ-013 ld_offset  in  2  byte address bits [1:0] of the load.
REQ-014 ram_result  in  DATA_W  RAM read data, valid exactly RAM_LAT cycles after ld_issue.
REQ-015 wb_en  out  1  register bank write enable (registered).
REQ-016 wb_rd  out  REG_AW  register bank write index (registered).
REQ-017 wb_data  out  DATA_W  register bank write data (registered).
REQ-018 stall  out  1  ALU skid buffer full; upstream holds its ALU result (registered).
REQ-019 ld_busy  out  1  at least one load in flight (combinational OR of pipeline valids).

Function
REQ-020 Load tracking SHALL be a RAM_LAT-stage shift pipeline carrying {valid, wr_ok, rd, size, signed, offset}; entry enters on ld_issue and reaches the tail RAM_LAT cycles later, with ram_result sampled at the tail.
REQ-021 Extraction at tail: word passes ram_result[DATA_W-1:0]; halfword selects ram_result[15:0] if offset[1]=0 else [31:16] (offset[0] ignored); byte selects lane offset of ram_result[31:0]; result sign- or zero-extended to DATA_W per signed.
REQ-022 Write-port priority each cycle: tail load with wr_ok=1 > buffered ALU entry > incoming ALU; exactly one writeback per cycle maximum.
REQ-023 Incoming ALU accepted only when stall=0; alu_valid while stall=1 SHALL be ignored.
REQ-024 Accepted ALU with no higher-priority claimant: wb_en=1, wb_rd=alu_rd, wb_data=alu_result on the next cycle (latency 1).
REQ-025 Accepted ALU colliding with a tail load: ALU entry written into the 1-entry skid buffer; stall=1 from the next cycle.
REQ-026 Buffer drains on the first cycle with no tail-load writeback; stall deasserts the cycle after drain.
REQ-027 Load writeback: ld_issue at cycle N -> wb_en=1 at N+RAM_LAT+1 with extracted data.
REQ-028 WAW squash: an accepted ALU whose alu_rd equals rd of any pipeline entry issued in an earlier cycle SHALL clear that entry's wr_ok; the load completes silently (no wb_en).
REQ-029 Same-cycle ld_issue and accepted alu_valid with equal rd: ALU is older; the new load is not squashed.
REQ-030 A tail load with wr_ok=1 whose rd equals the buffered ALU rd SHALL invalidate the buffer entry (load is younger); stall clears the following cycle.
REQ-031 Cycles with no writeback: wb_en=0, wb_rd and wb_data hold previous values.

Reset
REQ-032 reset_n=0 SHALL immediately clear wb_en, wb_rd, wb_data, stall to 0, all pipeline valids and the skid buffer; ld_busy reads 0.
REQ-033 Loads in flight at reset assertion SHALL never produce wb_en after reset_n rises, regardless of ram_result.
REQ-034 First ALU accepted in the cycle after reset_n rises SHALL write back with latency 1.

Verification
REQ-035 RAM_LAT=2: ld_issue cycle 0, rd=3, byte, signed, offset=2, ram_result=0x12_80_34_56 at cycle 2 -> cycle 3 wb_en=1, wb_rd=3, wb_data=0xFFFF_FF80.
REQ-036 Collision: load rd=1 issued cycle 0, ALU rd=2 data 0xAA at cycle 2 -> cycle 3 load writeback, stall=1 at cycle 3, cycle 4 wb_rd=2 data 0xAA, stall=0 at cycle 5.
REQ-037 WAW: load rd=5 issued cycle 0, ALU rd=5 data 0x77 at cycle 1 -> cycle 2 wb of 0x77; no wb_en at cycle 3.
REQ-038 Halfword unsigned, offset=3, ram_result=0x8001_0000 -> wb_data=0x0000_8001.
REQ-039 reset_n pulsed low at cycle 1 with load issued cycle 0 -> wb_en=0 through cycle 6; ld_busy=0 during and after reset.

Source files
------------

// File: rtl/writeback_select_if.sv
// writeback_select_if
//   Groups the writeback selector's bus signals.
//   master : upstream/RAM side. Drives ALU and load requests plus RAM read
//            data, and receives the register-bank write port, stall and ld_busy.
//   slave  : the writeback_select block itself.
interface writeback_select_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
);
  // ALU result port
  logic              alu_valid;
  logic [DATA_W-1:0] alu_result;
  logic [REG_AW-1:0] alu_rd;
  // load issue and RAM return
  logic              ld_issue;
  logic [REG_AW-1:0] ld_rd;
  logic [1:0]        ld_size;
  logic              ld_signed;
  logic [1:0]        ld_offset;
  logic [DATA_W-1:0] ram_result;
  // register bank write port and status
  logic              wb_en;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              stall;
  logic              ld_busy;

  modport master (
    output alu_valid, alu_result, alu_rd,
    output ld_issue, ld_rd, ld_size, ld_signed, ld_offset, ram_result,
    input  wb_en, wb_rd, wb_data, stall, ld_busy
  );

  modport slave (
    input  alu_valid, alu_result, alu_rd,
    input  ld_issue, ld_rd, ld_size, ld_signed, ld_offset, ram_result,
    output wb_en, wb_rd, wb_data, stall, ld_busy
  );
endinterface

// File: rtl/writeback_select.sv
// writeback_select
//   Arbitrates the single register-bank write port between ALU results and
//   loads returning from a fixed-latency RAM.
//   Load metadata travels through a RAM_LAT-deep shift pipeline, and
//   ram_result is sampled when the entry reaches the tail. A 1-entry skid
//   buffer holds an ALU result that collided with a load writeback.
//   Write-after-write ordering between ALU results and in-flight loads is
//   kept by squashing the older load's write.
// Ports
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : writeback_select_if.slave (ALU/load requests, RAM data,
//             wb_en/wb_rd/wb_data, stall, ld_busy)
module writeback_select #(
  parameter int DATA_W  = 32,  // >= 32
  parameter int REG_AW  = 4,
  parameter int RAM_LAT = 2    // 1..4
) (
  input  logic               clk,
  input  logic               reset_n,
  writeback_select_if.slave  bus
);

  localparam int TAIL = RAM_LAT - 1;

  typedef struct packed {
    logic              wr_ok;
    logic [REG_AW-1:0] rd;
    logic [1:0]        size;
    logic              sgn;
    logic [1:0]        off;
  } ld_ent_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } alu_ent_t;

  logic    [RAM_LAT-1:0] r_vld_pipe;
  ld_ent_t [RAM_LAT-1:0] r_ent_pipe;
  ld_ent_t [RAM_LAT-1:0] w_ent_sq;   // pipeline entries after WAW squash
  logic    [RAM_LAT-1:0] w_kill;
  ld_ent_t               w_ent_in;
  ld_ent_t               w_tail;

  alu_ent_t          r_buf;
  logic              r_buf_vld;
  logic              r_wb_en;
  logic [REG_AW-1:0] r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;

  logic              w_alu_acc;
  logic              w_tail_wr;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ld_data;

  // The skid buffer being full is exactly the stall condition. With a single
  // entry, an ALU result is only accepted when the buffer is empty.
  assign w_alu_acc = bus.alu_valid & ~r_buf_vld;

  assign w_ent_in = '{wr_ok: 1'b1, rd: bus.ld_rd, size: bus.ld_size,
                      sgn: bus.ld_signed, off: bus.ld_offset};

  // Every registered entry was issued before the current cycle, so an
  // accepted ALU result with the same rd is younger and the load must not
  // write. A load issued this very cycle is still on w_ent_in and is left
  // alone, because the ALU is the older of the two.
  always_comb begin
    for (int k = 0; k < RAM_LAT; k++) begin
      w_kill[k]         = w_alu_acc & r_vld_pipe[k] & (r_ent_pipe[k].rd == bus.alu_rd);
      w_ent_sq[k]       = r_ent_pipe[k];
      w_ent_sq[k].wr_ok = r_ent_pipe[k].wr_ok & ~w_kill[k];
    end
  end

  // A tail entry squashed in the same cycle lets the ALU take the port
  // directly.
  assign w_tail    = w_ent_sq[TAIL];
  assign w_tail_wr = r_vld_pipe[TAIL] & w_tail.wr_ok;

  // Lane extraction. The halfword select ignores offset[0].
  always_comb begin
    case (w_tail.off)
      2'd0:    w_byte = bus.ram_result[7:0];
      2'd1:    w_byte = bus.ram_result[15:8];
      2'd2:    w_byte = bus.ram_result[23:16];
      default: w_byte = bus.ram_result[31:24];
    endcase
    w_half = w_tail.off[1] ? bus.ram_result[31:16] : bus.ram_result[15:0];
    case (w_tail.size)
      2'b00:   w_ld_data = {{(DATA_W-8){w_tail.sgn & w_byte[7]}}, w_byte};
      2'b01:   w_ld_data = {{(DATA_W-16){w_tail.sgn & w_half[15]}}, w_half};
      default: w_ld_data = bus.ram_result;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_pipe <= '0;
      r_ent_pipe <= '0;
      r_buf      <= '0;
      r_buf_vld  <= 1'b0;
      r_wb_en    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_vld_pipe[0] <= bus.ld_issue;
      r_ent_pipe[0] <= w_ent_in;
      for (int k = 1; k < RAM_LAT; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        r_ent_pipe[k] <= w_ent_sq[k-1];
      end

      // Priority: tail load > buffered ALU > incoming ALU.
      if (w_tail_wr) begin
        r_wb_en   <= 1'b1;
        r_wb_rd   <= w_tail.rd;
        r_wb_data <= w_ld_data;
        // A buffered ALU entry with the same rd is older than this load, so
        // it is dropped.
        if (r_buf_vld && (r_buf.rd == w_tail.rd))
          r_buf_vld <= 1'b0;
        if (w_alu_acc) begin
          r_buf_vld <= 1'b1;
          r_buf     <= '{rd: bus.alu_rd, data: bus.alu_result};
        end
      end else if (r_buf_vld) begin
        r_wb_en   <= 1'b1;
        r_wb_rd   <= r_buf.rd;
        r_wb_data <= r_buf.data;
        r_buf_vld <= 1'b0;
      end else if (w_alu_acc) begin
        r_wb_en   <= 1'b1;
        r_wb_rd   <= bus.alu_rd;
        r_wb_data <= bus.alu_result;
      end else begin
        r_wb_en   <= 1'b0;
      end
    end
  end

  assign bus.wb_en   = r_wb_en;
  assign bus.wb_rd   = r_wb_rd;
  assign bus.wb_data = r_wb_data;
  assign bus.stall   = r_buf_vld;
  assign bus.ld_busy = |r_vld_pipe;

endmodule
